arb4_mux_ctrl: RTL
==================

# arb4_mux_ctrl

Round-robin arbiter and sequencer that shares the 4:1 single-bit mux datapath between four requesters. It accepts per-requester request lines, grants exactly one at a time, and drives the mux select from the winner. It registers the selected data bit as the shared output. A hold limit prevents one requester from monopolising the datapath.

## Interface
- `MAX_HOLD`, default 4: max consecutive grant cycles while another requester waits; 0 disables preemption. Legal range 0–255.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req` in 4: request, bit n = requester n; held high until done.
- `i0`, `i1`, `i2`, `i3` in 1 each: requester data bits.
- `gnt` out 4: one-hot grant, registered; all-zero when idle.
- `s` out 2: mux select = index of granted requester, registered.
- `q` out 1: registered selected data bit.
- `busy` out 1: 1 while in GRANT.
- `lock` in 1: present only with `ARB4_LOCK_EN`; see Configuration.

## Operation
- States: IDLE, GRANT. Internal: `ptr[1:0]` (highest-priority index) and `hold_cnt[7:0]`.
- Arbitration: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); winner = first set `req` bit in that order.
- IDLE: if `req != 0`, next edge enters GRANT, sets `gnt` = one-hot(winner) and `s` = winner, sets `ptr` = winner+1 (mod 4), and sets `hold_cnt` = 0. If `req == 0`, stay in IDLE.
- GRANT, per edge, evaluated in priority order:
  1. Release: `req[s]` = 0. Re-arbitrate among the other `req` bits. If any are set, grant the winner directly with no idle cycle. If none are set, go to IDLE with `gnt` = 0.
  2. Preempt: `MAX_HOLD` != 0, `hold_cnt == MAX_HOLD-1`, and some other `req` bit is set. Grant the winner among the other requesters, excluding the current holder.
  3. Otherwise: keep the grant. `hold_cnt` increments, saturating at 255.
- Every grant change updates `ptr` = new index+1 and clears `hold_cnt`.
- `hold_cnt` advances only when another requester is waiting. A lone requester holds indefinitely.
- `q` <= i[`s`] every edge in GRANT, using the current `s`. `q` holds its value in IDLE.
- `s` holds its last value in IDLE.
- `busy` = (state == GRANT).

## Timing
- Reset values: `gnt` = 0000, `s` = 00, `q` = 0, `busy` = 0, `ptr` = 00, `hold_cnt` = 0, state IDLE.
- Reset asserted mid-grant: all outputs and state go to reset values immediately, without waiting for a clock edge.
- Request-to-grant latency: 1 cycle from `req` sampled high in IDLE.
- Data latency: `q` reflects i[`s`] one edge after it is sampled, so the first valid `q` for a grant appears 1 cycle after `gnt` rises.
- Release-to-next-grant: 0 idle cycles. `gnt` switches one-hot to one-hot on the same edge; no cycle has two bits set.
- Simultaneous requests: resolved by `ptr`. After reset, requester 0 has highest priority.
- `ptr` wraps from 3 to 0.
- `req` rising on the current holder's bit is a no-op.
- `req` dropped by a non-granted requester before it is served: that request is lost, with no memory.

## Configuration
- `ARB4_LOCK_EN` defined: adds input `lock`. While `lock` = 1 in GRANT, preemption is suppressed and `hold_cnt` holds its value. Release by `req[s]` = 0 is still honoured. `lock` has no effect in IDLE.
- `ARB4_LOCK_EN` undefined: no `lock` port; preemption always governed by `MAX_HOLD`.

## Test plan
- Reset then `req` = 0001, i0 = 1: next edge `gnt` = 0001, `s` = 00, `busy` = 1; following edge `q` = 1; assert `rst_n` = 0 mid-grant -> `gnt` = 0000, `q` = 0 immediately.
- `req` = 1111 from reset, each requester dropping its `req` after its 2nd grant cycle: grant order 0, 1, 2, 3, 0, with no idle cycles between grants.
- `MAX_HOLD` = 4, `req` = 0011 held constant: `gnt` = 0001 for 4 cycles, then 0010 for 4 cycles, then 0001 again.
- `req` = 0100 alone for 20 cycles with `MAX_HOLD` = 4: `gnt` = 0100 throughout, with no preemption.
- With `ARB4_LOCK_EN`, `MAX_HOLD` = 2, `req` = 0011, `lock` = 1: `gnt` stays 0001 indefinitely. Deassert `lock`: switch to 0010 after 2 further cycles.
- Holder drops `req` while `req` = 1000 and `ptr` = 1: `gnt` goes to 1000 on the same edge. Then drop all `req`: `gnt` = 0000, `busy` = 0, and `q`/`s` hold their last values.

Source files
------------

// File: rtl/arb4_mux_ctrl.sv
// arb4_mux_ctrl: round-robin arbiter driving a shared 4:1 single-bit mux.
// Grants one of four requesters at a time, registers the selected data bit,
// and preempts a holder after MAX_HOLD cycles while others are waiting.
// Optional feature macro: ARB4_LOCK_EN adds a `lock` input that suppresses
// preemption and freezes the hold counter while asserted in GRANT.
module arb4_mux_ctrl #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef ARB4_LOCK_EN
    input  logic       lock,
`endif
    input  logic [3:0] req,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       q,
    output logic       busy
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned SW   = 2;
    localparam int unsigned HW   = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic          PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [HW-1:0] HOLD_LAST  = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT   = {HW{1'b1}};

    logic [0:0]      r_state;
    logic [SW-1:0]   r_ptr;
    logic [HW-1:0]   r_hold_cnt;

    logic [0:0]      w_nxt_state;
    logic [NREQ-1:0] w_nxt_gnt;
    logic [SW-1:0]   w_nxt_s;
    logic [SW-1:0]   w_nxt_ptr;
    logic [HW-1:0]   w_nxt_hold;
    logic            w_nxt_q;

    logic [NREQ-1:0] w_holder;
    logic [NREQ-1:0] w_others;
    logic [NREQ-1:0] w_data;
    logic [SW:0]     w_pick_all;
    logic [SW:0]     w_pick_oth;
    logic            w_do_grant;
    logic [SW-1:0]   w_win;
    logic            w_lock;

`ifdef ARB4_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // Round-robin search from p upward (mod 4); returns {found, index}.
    function automatic logic [SW:0] f_pick(input logic [NREQ-1:0] m, input logic [SW-1:0] p);
        logic [SW:0]   res;
        logic [SW-1:0] idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = p + SW'(k);
            if (m[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_holder   = NREQ'(4'b0001 << s);
    assign w_others   = req & ~w_holder;
    assign w_data     = {i3, i2, i1, i0};
    assign w_pick_all = f_pick(req, r_ptr);
    assign w_pick_oth = f_pick(w_others, r_ptr);

    assign busy = (r_state == ST_GRANT);

    // Next-state, grant decision and datapath capture.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = gnt;
        w_nxt_s     = s;
        w_nxt_ptr   = r_ptr;
        w_nxt_hold  = r_hold_cnt;
        w_nxt_q     = q;
        w_do_grant  = 1'b0;
        w_win       = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_all[SW]) begin
                    w_do_grant = 1'b1;
                    w_win      = w_pick_all[SW-1:0];
                end
            end
            ST_GRANT: begin
                w_nxt_q = w_data[s];
                if (!req[s]) begin
                    // Holder released: hand over directly or fall back to idle.
                    if (w_pick_oth[SW]) begin
                        w_do_grant = 1'b1;
                        w_win      = w_pick_oth[SW-1:0];
                    end else begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_gnt   = '0;
                    end
                end else if (PREEMPT_EN && !w_lock && (r_hold_cnt == HOLD_LAST) && (|w_others)) begin
                    w_do_grant = 1'b1;
                    w_win      = w_pick_oth[SW-1:0];
                end else if ((|w_others) && !w_lock && (r_hold_cnt != HOLD_SAT)) begin
                    w_nxt_hold = r_hold_cnt + HW'(1);
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_gnt   = '0;
            end
        endcase

        if (w_do_grant) begin
            w_nxt_state = ST_GRANT;
            w_nxt_gnt   = NREQ'(4'b0001 << w_win);
            w_nxt_s     = w_win;
            w_nxt_ptr   = w_win + SW'(1);
            w_nxt_hold  = '0;
        end
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            gnt        <= '0;
            s          <= '0;
            q          <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_ptr      <= w_nxt_ptr;
            r_hold_cnt <= w_nxt_hold;
            gnt        <= w_nxt_gnt;
            s          <= w_nxt_s;
            q          <= w_nxt_q;
        end
    end

endmodule
